// File: rtl/median_filter_ctrl_pkg.sv
// median_filter_ctrl_pkg: shared FSM states, error codes and pixel width for the frame controller
package median_filter_ctrl_pkg;
    localparam int PIXEL_W = 8;
    typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, DONE, ERR} ctrl_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_EARLY_DONE, ERR_COUNT_MISMATCH, ERR_TIMEOUT} ctrl_err_e;
endpackage

// File: rtl/frame_pixel_counter.sv
// frame_pixel_counter: CW-bit pixel counter with clear, increment, saturation and terminal-count flag
module frame_pixel_counter #(
    parameter int CW   = 4,
    parameter int TERM = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);
    // clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    assign tc = count == CW'(TERM);
endmodule

// File: rtl/median_filter_frame_ctrl.sv
// median_filter_frame_ctrl: frame sequencer in front of median_filter; MEDIAN_CTRL_TIMEOUT_EN enables a DRAIN watchdog
module median_filter_frame_ctrl
    import median_filter_ctrl_pkg::*;
#(
    parameter int IMAGE_LEN      = 1080,
    parameter int IMAGE_HEIGHT   = 720,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int PIXELS        = IMAGE_LEN * IMAGE_HEIGHT,
    localparam int CW            = $clog2(PIXELS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_req_i,
    input  logic               abort_i,
    input  logic               clear_err_i,
    input  logic               src_valid_i,
    output logic               src_ready_o,
    input  logic [PIXEL_W-1:0] src_red_i,
    input  logic [PIXEL_W-1:0] src_green_i,
    input  logic [PIXEL_W-1:0] src_blue_i,
    output logic               filt_start_o,
    output logic               filt_valid_o,
    output logic [PIXEL_W-1:0] filt_red_o,
    output logic [PIXEL_W-1:0] filt_green_o,
    output logic [PIXEL_W-1:0] filt_blue_o,
    input  logic               filt_valid_i,
    input  logic               filt_done_i,
    output logic               frame_ack_o,
    output logic               frame_done_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [CW-1:0]      in_count_o,
    output logic [CW-1:0]      out_count_o
);
    ctrl_state_e state, state_nx;
    ctrl_err_e   err_code, err_nx;
    logic        fwd, out_inc, in_tc, out_tc, match, tmo;

    assign src_ready_o  = state == FEED;
    assign filt_start_o = state == START;
    assign frame_ack_o  = state == START;
    assign frame_done_o = state == DONE;
    assign busy_o       = state != IDLE;
    assign err_o        = state == ERR;
    assign err_code_o   = err_code;
    // a pixel taken alongside abort or an early done is dropped, not forwarded
    assign fwd          = src_valid_i & src_ready_o & ~abort_i & ~filt_done_i;
    assign out_inc      = filt_valid_i & (state == FEED || state == DRAIN) & ~abort_i;
    // total including a filter output arriving in the same cycle as done
    assign match        = filt_valid_i ? out_count_o == CW'(PIXELS - 1) : out_tc;

    frame_pixel_counter #(.CW(CW), .TERM(PIXELS - 1)) u_in_cnt (
        .clk(clk), .rst(rst), .clr(state == START), .inc(fwd), .count(in_count_o), .tc(in_tc)
    );

    frame_pixel_counter #(.CW(CW), .TERM(PIXELS)) u_out_cnt (
        .clk(clk), .rst(rst), .clr(state == START), .inc(out_inc), .count(out_count_o), .tc(out_tc)
    );

`ifdef MEDIAN_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd;
    // idle cycles spent in DRAIN since entry or since the last filter output
    always_ff @(posedge clk or posedge rst)
        if (rst)
            wd <= '0;
        else
            wd <= (state != DRAIN || filt_valid_i) ? '0 : wd + 1'b1;
    assign tmo = state == DRAIN && !filt_valid_i && wd == TW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    // state and error-code registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nx;
            err_code <= err_nx;
        end

    // one-cycle registered pixel path into the filter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            filt_valid_o <= 1'b0;
            filt_red_o   <= '0;
            filt_green_o <= '0;
            filt_blue_o  <= '0;
        end else begin
            filt_valid_o <= fwd;
            if (fwd) begin
                filt_red_o   <= src_red_i;
                filt_green_o <= src_green_i;
                filt_blue_o  <= src_blue_i;
            end
        end

    // next state and error classification; abort overrides every transition
    always_comb begin
        state_nx = state;
        err_nx   = err_code;
        case (state)
            IDLE:  if (frame_req_i) state_nx = START;
            START: begin
                state_nx = FEED;
                err_nx   = ERR_NONE;
            end
            FEED:
                if (filt_done_i) begin
                    state_nx = ERR;
                    err_nx   = ERR_EARLY_DONE;
                end else if (fwd && in_tc)
                    state_nx = DRAIN;
            DRAIN:
                if (filt_done_i) begin
                    state_nx = match ? DONE : ERR;
                    err_nx   = match ? err_code : ERR_COUNT_MISMATCH;
                end else if (tmo) begin
                    state_nx = ERR;
                    err_nx   = ERR_TIMEOUT;
                end
            DONE:  state_nx = IDLE;
            ERR:   if (clear_err_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_i) state_nx = IDLE;
    end
endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// tb_median_filter_frame_ctrl: randomized scoreboard bench for the frame controller
module tb_median_filter_frame_ctrl;
    localparam int PIXELS = 12;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CW = $clog2(PIXELS + 1);
    localparam int M_NORMAL = 0, M_DONE_LAST = 1, M_EARLY = 2, M_ABORT = 3, M_RST = 4, M_NODONE = 5;

    logic clk, rst, frame_req_i, abort_i, clear_err_i, src_valid_i, src_ready_o;
    logic [7:0] src_red_i, src_green_i, src_blue_i, filt_red_o, filt_green_o, filt_blue_o;
    logic filt_start_o, filt_valid_o, filt_valid_i, filt_done_i;
    logic frame_ack_o, frame_done_o, busy_o, err_o;
    logic [1:0] err_code_o;
    logic [CW-1:0] in_count_o, out_count_o;

    int total = 0, bad = 0, cyc = 0;
    int frames = 0, dones_exp = 0, dones_seen = 0, starts_seen = 0;
    logic [23:0] exp_q[$];
    int stamp_q[$];

    median_filter_frame_ctrl #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst), .frame_req_i(frame_req_i), .abort_i(abort_i), .clear_err_i(clear_err_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .src_red_i(src_red_i), .src_green_i(src_green_i), .src_blue_i(src_blue_i),
        .filt_start_o(filt_start_o), .filt_valid_o(filt_valid_o),
        .filt_red_o(filt_red_o), .filt_green_o(filt_green_o), .filt_blue_o(filt_blue_o),
        .filt_valid_i(filt_valid_i), .filt_done_i(filt_done_i),
        .frame_ack_o(frame_ack_o), .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o),
        .err_code_o(err_code_o), .in_count_o(in_count_o), .out_count_o(out_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every forwarded pixel must match the next queued transfer, one cycle later
    always @(negedge clk) begin
        logic [23:0] e;
        int s;
        if (!rst) begin
            if (filt_valid_o) begin
                if (exp_q.size() == 0)
                    check("pix_unexpected", {filt_red_o, filt_green_o, filt_blue_o}, -1);
                else begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    check("pix_data", {filt_red_o, filt_green_o, filt_blue_o}, e);
                    check("pix_time", cyc, s);
                end
            end
            if (frame_done_o) dones_seen++;
            if (filt_start_o) starts_seen++;
        end
    end

    task automatic run_frame(input int mode, input bit gaps, input int n_out, input int at);
        int nin, nout, it, n;
        logic [23:0] px;
        bit v, fv;
        nin = 0;
        nout = 0;
        frame_req_i = 1'b1;
        @(negedge clk);
        frame_req_i = 1'b0;
        frames++;
        check("ack", frame_ack_o, 1);
        check("start", filt_start_o, 1);
        check("start_ready", src_ready_o, 0);
        @(negedge clk);
        check("start_one_cycle", filt_start_o, 0);
        check("in_cleared", in_count_o, 0);
        it = 0;
        while (nin < PIXELS && it < 400) begin
            it++;
            check("ready_feed", src_ready_o, 1);
            if (nin == at && mode == M_EARLY) begin
                filt_done_i = 1'b1;
                @(negedge clk);
                filt_done_i = 1'b0;
                check("early_err", err_o, 1);
                check("early_code", err_code_o, 1);
                check("early_ready", src_ready_o, 0);
                clear_err_i = 1'b1;
                @(negedge clk);
                clear_err_i = 1'b0;
                check("early_clear_busy", busy_o, 0);
                check("early_clear_err", err_o, 0);
                return;
            end
            if (nin == at && mode == M_ABORT) begin
                {src_red_i, src_green_i, src_blue_i} = 24'($urandom);
                src_valid_i = 1'b1;
                abort_i = 1'b1;
                @(negedge clk);
                abort_i = 1'b0;
                src_valid_i = 1'b0;
                check("abort_busy", busy_o, 0);
                check("abort_fv", filt_valid_o, 0);
                check("abort_no_done", frame_done_o, 0);
                check("abort_in_hold", in_count_o, at);
                return;
            end
            if (nin == at && mode == M_RST) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("rst_busy", busy_o, 0);
                check("rst_fv", filt_valid_o, 0);
                check("rst_ready", src_ready_o, 0);
                check("rst_in", in_count_o, 0);
                check("rst_out", out_count_o, 0);
                check("rst_pix", {filt_red_o, filt_green_o, filt_blue_o}, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            px = 24'($urandom);
            {src_red_i, src_green_i, src_blue_i} = px;
            src_valid_i = v;
            frame_req_i = 1'($urandom_range(0, 1));
            if (v) begin
                exp_q.push_back(px);
                stamp_q.push_back(cyc + 1);
                nin++;
            end
            fv = gaps && nout < n_out - 1 && $urandom_range(0, 3) == 0;
            filt_valid_i = fv;
            if (fv) nout++;
            @(negedge clk);
            src_valid_i = 1'b0;
            filt_valid_i = 1'b0;
            frame_req_i = 1'b0;
        end
        check("feed_bound", nin, PIXELS);
        check("ready_drain", src_ready_o, 0);
        check("busy_drain", busy_o, 1);
        if (mode == M_NODONE) begin
            n = 0;
            while (!err_o && n < 120) begin
                @(negedge clk);
                n++;
            end
`ifdef MEDIAN_CTRL_TIMEOUT_EN
            check("tmo_cycles", n, TIMEOUT_CYCLES);
            check("tmo_code", err_code_o, 3);
            clear_err_i = 1'b1;
            @(negedge clk);
            clear_err_i = 1'b0;
            check("tmo_clear", busy_o, 0);
`else
            check("no_tmo_busy", busy_o, 1);
            check("no_tmo_err", err_o, 0);
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
            check("no_tmo_abort", busy_o, 0);
`endif
            return;
        end
        it = 0;
        while (nout < n_out && it < 400) begin
            it++;
            fv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            filt_valid_i = fv;
            if (fv) nout++;
            filt_done_i = mode == M_DONE_LAST && fv && nout == n_out;
            @(negedge clk);
            filt_valid_i = 1'b0;
            filt_done_i = 1'b0;
        end
        if (mode != M_DONE_LAST) begin
            filt_done_i = 1'b1;
            @(negedge clk);
            filt_done_i = 1'b0;
        end
        if (nout == PIXELS) begin
            dones_exp++;
            check("done_pulse", frame_done_o, 1);
            check("done_err", err_o, 0);
            check("done_in", in_count_o, PIXELS);
            check("done_out", out_count_o, nout);
            filt_valid_i = 1'b1;
            @(negedge clk);
            filt_valid_i = 1'b0;
            check("done_one_cycle", frame_done_o, 0);
            check("idle_busy", busy_o, 0);
            check("idle_in_hold", in_count_o, PIXELS);
            check("idle_out_hold", out_count_o, PIXELS);
        end else begin
            check("mm_err", err_o, 1);
            check("mm_code", err_code_o, 2);
            check("mm_no_done", frame_done_o, 0);
            check("mm_out", out_count_o, nout);
            clear_err_i = 1'b1;
            @(negedge clk);
            clear_err_i = 1'b0;
            check("mm_clear", busy_o, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {frame_req_i, abort_i, clear_err_i, src_valid_i, filt_valid_i, filt_done_i} = '0;
        {src_red_i, src_green_i, src_blue_i} = '0;
        repeat (3) @(negedge clk);
        check("rst_busy0", busy_o, 0);
        check("rst_ready0", src_ready_o, 0);
        check("rst_fv0", filt_valid_o, 0);
        check("rst_start0", filt_start_o, 0);
        check("rst_ack0", frame_ack_o, 0);
        check("rst_done0", frame_done_o, 0);
        check("rst_err0", err_o, 0);
        check("rst_code0", err_code_o, 0);
        check("rst_in0", in_count_o, 0);
        check("rst_out0", out_count_o, 0);
        check("rst_pix0", {filt_red_o, filt_green_o, filt_blue_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(M_NORMAL, 1'b0, 12, -1);
        repeat (3) run_frame(M_NORMAL, 1'b1, 12, -1);
        run_frame(M_DONE_LAST, 1'b1, 12, -1);
        run_frame(M_NORMAL, 1'b1, 11, -1);
        run_frame(M_DONE_LAST, 1'b0, 11, -1);
        run_frame(M_EARLY, 1'b0, 12, 5);
        run_frame(M_ABORT, 1'b0, 12, 7);
        run_frame(M_NORMAL, 1'b0, 12, -1);
        run_frame(M_RST, 1'b1, 12, 4);
        run_frame(M_NODONE, 1'b0, 0, -1);
        run_frame(M_NORMAL, 1'b1, 12, -1);
        repeat (3) @(negedge clk);
        check("q_empty", exp_q.size(), 0);
        check("done_count", dones_seen, dones_exp);
        check("start_count", starts_seen, frames);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
